// File: rtl/updown_mod_counter.sv
// Up/down modulo-M counter with synchronous load, count enable, a registered
// terminal-count pulse for cascading, and a sticky wrap flag.
module updown_mod_counter #(
    parameter int n           = 4,
    parameter int MOD_DEFAULT = 2**n
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [n-1:0] d,
    input  logic [n-1:0] mod_val,
    output logic [n-1:0] Q,
    output logic         tc,
    output logic         wrap
);

    // One extra bit so a default modulus of 2**n is representable.
    localparam logic [n:0] MOD_DEF_W = (n+1)'(MOD_DEFAULT);

    logic [n-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic         wrap_q, wrap_d;

    logic [n:0]   m_eff;
    logic [n:0]   max_cnt;
    logic [n:0]   q_ext;
    logic [n:0]   d_ext;

    always_comb begin
        m_eff   = (mod_val == '0) ? MOD_DEF_W : {1'b0, mod_val};
        max_cnt = m_eff - (n+1)'(1);
        q_ext   = {1'b0, q_q};
        d_ext   = {1'b0, d};
    end

    always_comb begin
        q_d    = q_q;
        tc_d   = 1'b0;
        wrap_d = wrap_q;
        if (load) begin
            q_d    = (d_ext < m_eff) ? d : max_cnt[n-1:0];
            wrap_d = 1'b0;
        end else if (en) begin
            if (up) begin
                if (q_ext < max_cnt) begin
                    q_d = q_q + n'(1);
                end else begin
                    // Also pulls an out-of-range count back after mod_val shrinks.
                    q_d    = '0;
                    tc_d   = 1'b1;
                    wrap_d = 1'b1;
                end
            end else begin
                if ((q_q != '0) && (q_ext <= max_cnt)) begin
                    q_d = q_q - n'(1);
                end else begin
                    q_d    = max_cnt[n-1:0];
                    tc_d   = 1'b1;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            tc_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tc_q   <= tc_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign tc   = tc_q;
    assign wrap = wrap_q;

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's free-running up counter.
- Adds:
  - Programmable modulus.
  - Up/down direction.
  - Synchronous load.
  - Count enable.
  - Terminal-count pulse for cascading.
- Used as a general-purpose timebase/divider and event counter in the 50-day RTL library. Chains via en/tc.

Parameters:
n, 4, counter width in bits (n >= 2)
MOD_DEFAULT, 2**n, modulus used when mod_val == 0; count range is 0..MOD-1

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
en  input  1  count enable; counter holds when low
up  input  1  direction: 1 = count up, 0 = count down
load  input  1  synchronous load strobe
d  input  n  load value
mod_val  input  n  runtime modulus (0 selects MOD_DEFAULT)
Q  output  n  current count (registered)
tc  output  1  terminal-count pulse (registered)
wrap  output  1  sticky wrap flag, cleared by load

Behaviour:
- Reset (reset_n = 0, asynchronous): Q = 0, tc = 0, wrap = 0 immediately, independent of clk.
- Effective modulus M:
  - M = mod_val when mod_val != 0.
  - Otherwise M = MOD_DEFAULT, computed in n+1 bits so that 2**n is representable.
  - The maximum count is M-1.
- Priority each rising edge: load > en > hold.
- load = 1:
  - If d < M: Q <= d.
  - If d >= M: Q <= M-1 (saturating clamp).
  - tc <= 0, wrap <= 0.
  - Load applies regardless of en.
- en = 1, up = 1:
  - Q <= Q+1 if Q < M-1.
  - Q <= 0 if Q >= M-1 (wrap; also recovers an out-of-range Q after a mod_val change).
- en = 1, up = 0:
  - Q <= Q-1 if Q != 0 and Q <= M-1.
  - Q <= M-1 if Q == 0 or Q > M-1.
- en = 0: Q, wrap hold; tc <= 0.
- tc:
  - tc <= 1 for exactly one cycle, coincident with the cycle in which Q takes the wrapped value (0 when counting up, M-1 when counting down).
  - tc is asserted on the same edge that performs the wrap. It is a registered output, not combinational.
- wrap: set on the same edge tc is set; stays set until load or reset.
- Direction change mid-count takes effect on the next enabled edge; there is no extra latency.
- mod_val changes are sampled every edge; no pipeline stage.
- M = 1 (mod_val = 1):
  - Q stays 0.
  - tc = 1 on every enabled cycle.
- Reset asserted mid-count: outputs clear asynchronously.
  - Counting resumes from 0 on the first rising edge after reset_n deasserts with en = 1, giving Q = 1 when up = 1.
- Latency: one clock from any control input to Q and tc.

Test Plan:
- Reset during operation:
  - Stimulus: count to Q = 5 with n = 4, then pulse reset_n low for 2 ns between edges.
  - Response: Q = 0, tc = 0, wrap = 0 before the next edge; Q = 1 one edge after release.
- Up wrap, mod_val = 10, up = 1, en = 1 from Q = 0:
  - Q follows 0..9 then returns to 0 on the 10th edge.
  - tc = 1 only in the cycle with Q = 0 after the wrap.
  - wrap = 1 from then on.
- Down wrap, mod_val = 0 (M = 16), up = 0 from Q = 2:
  - Q follows 1, 0, 15, 14.
  - tc high only in the cycle Q = 15.
- Load and clamp with mod_val = 10:
  - load = 1, d = 7, en = 0 gives Q = 7 next cycle and wrap = 0.
  - load = 1, d = 12 gives Q = 9.
  - load and en both high: load wins.
- Enable and direction:
  - en = 0 for 3 cycles: Q holds and tc stays 0.
  - Toggle up between edges at Q = 4: Q follows 5, 4, 3.
- Runtime modulus shrink:
  - At Q = 12, set mod_val = 8 with up = 1: the next edge gives Q = 0 and tc = 1.
  - With up = 0 instead: the next edge gives Q = 7.
